// File: rtl/dmem_arbiter_if.sv
// Bus bundle for the data-memory arbiter: pipeline port, debug port,
// memory command/response port, plus the stall and error indications.
interface dmem_arbiter_if #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 64
);
  logic              p_req;
  logic              p_we;
  logic [ADDR_W-1:0] p_addr;
  logic [DATA_W-1:0] p_wdata;
  logic              p_ack;
  logic [DATA_W-1:0] p_rdata;
  logic              pipe_stall;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_ack;
  logic [DATA_W-1:0] d_rdata;

  logic              m_valid;
  logic              m_we;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata;
  logic              m_done;
  logic [DATA_W-1:0] m_rdata;

  logic              err;

  // Arbiter side: serves the requesters, commands the memory
  modport slave (
    input  p_req, p_we, p_addr, p_wdata,
    output p_ack, p_rdata, pipe_stall,
    input  d_req, d_we, d_addr, d_wdata,
    output d_ack, d_rdata,
    output m_valid, m_we, m_addr, m_wdata,
    input  m_done, m_rdata,
    output err
  );

  // Environment side: requesters and memory model
  modport master (
    output p_req, p_we, p_addr, p_wdata,
    input  p_ack, p_rdata, pipe_stall,
    output d_req, d_we, d_addr, d_wdata,
    input  d_ack, d_rdata,
    input  m_valid, m_we, m_addr, m_wdata,
    output m_done, m_rdata,
    input  err
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter/sequencer. Shares one multi-cycle memory between the
// pipeline MEM stage and a debug/loader port, with anti-starvation for debug,
// a BUSY timeout that aborts hung accesses, and the pipeline stall output.
module dmem_arbiter #(
  parameter int DATA_W     = 64,
  parameter int ADDR_W     = 64,
  parameter int STARVE_MAX = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  dmem_arbiter_if.slave bus
);

  localparam int STARVE_W = $clog2(STARVE_MAX + 1);
  localparam int TCNT_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);
  localparam logic [TCNT_W-1:0]   TCNT_LIM   = TCNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_P = 2'd1,
    BUSY_D = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t r_state;
  state_t w_next_state;

  logic                r_m_valid;
  logic                r_m_we;
  logic [ADDR_W-1:0]   r_m_addr;
  logic [DATA_W-1:0]   r_m_wdata;
  logic [DATA_W-1:0]   r_p_rdata;
  logic [DATA_W-1:0]   r_d_rdata;
  logic                r_p_ack;
  logic                r_d_ack;
  logic                r_err;
  logic [STARVE_W-1:0] r_starve;
  logic [TCNT_W-1:0]   r_tcnt;

  logic w_p_cand;
  logic w_d_cand;
  logic w_grant_p;
  logic w_grant_d;
  logic w_done;
  logic w_timeout;
  logic w_busy;

  assign w_busy = (r_state == BUSY_P) || (r_state == BUSY_D);

  // Next-state and grant/completion decode; a requester being acked this cycle is not eligible
  always_comb begin
    w_next_state = r_state;
    w_grant_p    = 1'b0;
    w_grant_d    = 1'b0;
    w_done       = 1'b0;
    w_timeout    = 1'b0;
    w_p_cand     = bus.p_req & ~r_p_ack;
    w_d_cand     = bus.d_req & ~r_d_ack;
    case (r_state)
      IDLE: begin
        if (w_d_cand && ((r_starve == STARVE_LIM) || !w_p_cand)) begin
          w_grant_d    = 1'b1;
          w_next_state = BUSY_D;
        end else if (w_p_cand) begin
          w_grant_p    = 1'b1;
          w_next_state = BUSY_P;
        end
      end
      BUSY_P, BUSY_D: begin
        if (bus.m_done) begin
          w_done       = 1'b1;
          w_next_state = RESP;
        end else if (r_tcnt == TCNT_LIM) begin
          w_timeout    = 1'b1;
          w_next_state = RESP;
        end
      end
      RESP: begin
        w_next_state = IDLE;
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Memory command latch, response capture, ack/err pulses and the counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_m_valid <= 1'b0;
      r_m_we    <= 1'b0;
      r_m_addr  <= '0;
      r_m_wdata <= '0;
      r_p_rdata <= '0;
      r_d_rdata <= '0;
      r_p_ack   <= 1'b0;
      r_d_ack   <= 1'b0;
      r_err     <= 1'b0;
      r_starve  <= '0;
      r_tcnt    <= '0;
    end else begin
      r_p_ack <= 1'b0;
      r_d_ack <= 1'b0;
      r_err   <= 1'b0;

      if (w_grant_p || w_grant_d) begin
        r_m_valid <= 1'b1;
        r_m_we    <= w_grant_d ? bus.d_we    : bus.p_we;
        r_m_addr  <= w_grant_d ? bus.d_addr  : bus.p_addr;
        r_m_wdata <= w_grant_d ? bus.d_wdata : bus.p_wdata;
        r_tcnt    <= '0;
      end

      if (r_state == IDLE) begin
        if (w_grant_d || !bus.d_req) begin
          r_starve <= '0;
        end else if (w_grant_p && (r_starve != STARVE_LIM)) begin
          r_starve <= r_starve + 1'b1;
        end
      end

      if (w_done) begin
        r_m_valid <= 1'b0;
        if (r_state == BUSY_D) begin
          r_d_rdata <= bus.m_rdata;
          r_d_ack   <= 1'b1;
        end else begin
          r_p_rdata <= bus.m_rdata;
          r_p_ack   <= 1'b1;
        end
      end else if (w_timeout) begin
        r_m_valid <= 1'b0;
        r_err     <= 1'b1;
        if (r_state == BUSY_D) begin
          r_d_rdata <= '0;
          r_d_ack   <= 1'b1;
        end else begin
          r_p_rdata <= '0;
          r_p_ack   <= 1'b1;
        end
      end else if (w_busy) begin
        r_tcnt <= r_tcnt + 1'b1;
      end
    end
  end

  assign bus.m_valid    = r_m_valid;
  assign bus.m_we       = r_m_we;
  assign bus.m_addr     = r_m_addr;
  assign bus.m_wdata    = r_m_wdata;
  assign bus.p_ack      = r_p_ack;
  assign bus.p_rdata    = r_p_rdata;
  assign bus.d_ack      = r_d_ack;
  assign bus.d_rdata    = r_d_rdata;
  assign bus.err        = r_err;
  assign bus.pipe_stall = bus.p_req & ~r_p_ack;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed testbench for dmem_arbiter: load, debug write, starvation relief,
// timeout abort, done-vs-timeout race and reset in the middle of an access.
module tb_dmem_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  dmem_arbiter_if #(.DATA_W(64), .ADDR_W(64)) bus ();

  dmem_arbiter #(
    .DATA_W(64), .ADDR_W(64), .STARVE_MAX(4), .TIMEOUT(16)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.p_req = 0; bus.p_we = 0; bus.p_addr = '0; bus.p_wdata = '0;
    bus.d_req = 0; bus.d_we = 0; bus.d_addr = '0; bus.d_wdata = '0;
    bus.m_done = 0; bus.m_rdata = '0;
    tick(); tick();
    checks++; if (bus.m_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_m_valid got %0h want 0", bus.m_valid); end
    checks++; if (bus.m_we !== 1'b0) begin errors++; $display("[TB] FAIL rst_m_we got %0h want 0", bus.m_we); end
    checks++; if (bus.m_addr !== 64'h0) begin errors++; $display("[TB] FAIL rst_m_addr got %0h want 0", bus.m_addr); end
    checks++; if (bus.m_wdata !== 64'h0) begin errors++; $display("[TB] FAIL rst_m_wdata got %0h want 0", bus.m_wdata); end
    checks++; if ({bus.p_ack, bus.d_ack, bus.err} !== 3'b000) begin errors++; $display("[TB] FAIL rst_acks got %b want 000", {bus.p_ack, bus.d_ack, bus.err}); end
    checks++; if (bus.p_rdata !== 64'h0 || bus.d_rdata !== 64'h0) begin errors++; $display("[TB] FAIL rst_rdata got %0h/%0h want 0/0", bus.p_rdata, bus.d_rdata); end
    checks++; if (bus.pipe_stall !== 1'b0) begin errors++; $display("[TB] FAIL rst_stall got %0h want 0", bus.pipe_stall); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_pipe_load();
    bus.p_req = 1; bus.p_we = 0; bus.p_addr = 64'h10;
    #1;
    checks++; if (bus.pipe_stall !== 1'b1) begin errors++; $display("[TB] FAIL load_stall_early got %0h want 1", bus.pipe_stall); end
    checks++; if (bus.m_valid !== 1'b0) begin errors++; $display("[TB] FAIL load_valid_early got %0h want 0", bus.m_valid); end
    tick();
    checks++; if (bus.m_valid !== 1'b1) begin errors++; $display("[TB] FAIL load_valid got %0h want 1", bus.m_valid); end
    checks++; if (bus.m_addr !== 64'h10 || bus.m_we !== 1'b0) begin errors++; $display("[TB] FAIL load_cmd got addr %0h we %0h want 10/0", bus.m_addr, bus.m_we); end
    checks++; if (bus.pipe_stall !== 1'b1 || bus.p_ack !== 1'b0) begin errors++; $display("[TB] FAIL load_busy got stall %0h ack %0h want 1/0", bus.pipe_stall, bus.p_ack); end
    bus.m_done = 1; bus.m_rdata = 64'hDEAD;
    tick();
    bus.m_done = 0;
    checks++; if (bus.p_ack !== 1'b1) begin errors++; $display("[TB] FAIL load_ack got %0h want 1", bus.p_ack); end
    checks++; if (bus.p_rdata !== 64'hDEAD) begin errors++; $display("[TB] FAIL load_rdata got %0h want dead", bus.p_rdata); end
    checks++; if (bus.pipe_stall !== 1'b0 || bus.m_valid !== 1'b0 || bus.err !== 1'b0) begin errors++; $display("[TB] FAIL load_resp got stall %0h valid %0h err %0h want 0/0/0", bus.pipe_stall, bus.m_valid, bus.err); end
    bus.p_req = 0;
    tick();
    checks++; if (bus.p_ack !== 1'b0) begin errors++; $display("[TB] FAIL load_ack_once got %0h want 0", bus.p_ack); end
  endtask

  task automatic test_debug_write();
    int bad = 0;
    bus.d_req = 1; bus.d_we = 1; bus.d_addr = 64'h20; bus.d_wdata = 64'h55; bus.m_rdata = 64'hAAAA;
    for (int c = 0; c < 3; c++) begin
      tick();
      if (bus.m_valid !== 1'b1 || bus.m_we !== 1'b1 || bus.m_addr !== 64'h20 ||
          bus.m_wdata !== 64'h55 || bus.d_ack !== 1'b0) bad++;
      if (c == 2) bus.m_done = 1;
    end
    checks++; if (bad !== 0) begin errors++; $display("[TB] FAIL dwr_hold got %0d bad cycles want 0", bad); end
    tick();
    bus.m_done = 0;
    checks++; if (bus.d_ack !== 1'b1 || bus.p_ack !== 1'b0) begin errors++; $display("[TB] FAIL dwr_ack got d %0h p %0h want 1/0", bus.d_ack, bus.p_ack); end
    checks++; if (bus.err !== 1'b0) begin errors++; $display("[TB] FAIL dwr_err got %0h want 0", bus.err); end
    bus.d_req = 0;
    tick();
    checks++; if (bus.d_ack !== 1'b0 || bus.m_valid !== 1'b0) begin errors++; $display("[TB] FAIL dwr_once got ack %0h valid %0h want 0/0", bus.d_ack, bus.m_valid); end
  endtask

  task automatic test_starvation();
    logic [63:0] expAddr;
    bus.p_we = 0; bus.p_addr = 64'h100; bus.d_we = 0; bus.d_addr = 64'h200;
    bus.m_rdata = 64'hBEEF;
    bus.p_req = 1; bus.d_req = 1;
    for (int i = 0; i < 6; i++) begin
      expAddr = (i == 4) ? 64'h200 : 64'h100;
      tick();
      checks++; if (bus.m_valid !== 1'b1 || bus.m_addr !== expAddr) begin errors++; $display("[TB] FAIL starve_grant%0d got valid %0h addr %0h want 1/%0h", i, bus.m_valid, bus.m_addr, expAddr); end
      bus.m_done = 1;
      tick();
      bus.m_done = 0;
      checks++; if (bus.p_ack !== 1'(i != 4) || bus.d_ack !== 1'(i == 4)) begin errors++; $display("[TB] FAIL starve_ack%0d got p %0h d %0h want %0h/%0h", i, bus.p_ack, bus.d_ack, 1'(i != 4), 1'(i == 4)); end
      if (i == 5) begin bus.p_req = 0; bus.d_req = 0; end
      tick();
      checks++; if (bus.m_valid !== 1'b0) begin errors++; $display("[TB] FAIL starve_gap%0d got %0h want 0", i, bus.m_valid); end
    end
  endtask

  task automatic test_timeout();
    int  cnt  = 0;
    bit  seen = 0;
    bus.p_we = 0; bus.p_addr = 64'h30; bus.p_req = 1; bus.m_done = 0;
    for (int c = 0; c < 40 && !seen; c++) begin
      tick();
      if (bus.p_ack === 1'b1) seen = 1;
      else if (bus.m_valid === 1'b1) cnt++;
    end
    checks++; if (seen !== 1'b1) begin errors++; $display("[TB] FAIL tmo_ack got %0h want 1", seen); end
    checks++; if (cnt !== 16) begin errors++; $display("[TB] FAIL tmo_busy_cycles got %0d want 16", cnt); end
    checks++; if (bus.err !== 1'b1 || bus.m_valid !== 1'b0) begin errors++; $display("[TB] FAIL tmo_err got err %0h valid %0h want 1/0", bus.err, bus.m_valid); end
    checks++; if (bus.p_rdata !== 64'h0) begin errors++; $display("[TB] FAIL tmo_rdata got %0h want 0", bus.p_rdata); end
    bus.p_req = 0;
    tick();
    checks++; if (bus.err !== 1'b0 || bus.p_ack !== 1'b0) begin errors++; $display("[TB] FAIL tmo_pulse got err %0h ack %0h want 0/0", bus.err, bus.p_ack); end
    tick();
    checks++; if (bus.m_valid !== 1'b0) begin errors++; $display("[TB] FAIL tmo_idle got %0h want 0", bus.m_valid); end
  endtask

  task automatic test_done_at_timeout();
    int bad = 0;
    bus.p_addr = 64'h38; bus.m_rdata = 64'h1234; bus.p_req = 1;
    for (int c = 0; c < 16; c++) begin
      tick();
      if (bus.m_valid !== 1'b1 || bus.p_ack !== 1'b0) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("[TB] FAIL race_busy got %0d bad cycles want 0", bad); end
    bus.m_done = 1;
    tick();
    bus.m_done = 0;
    checks++; if (bus.p_ack !== 1'b1 || bus.err !== 1'b0) begin errors++; $display("[TB] FAIL race_ack got ack %0h err %0h want 1/0", bus.p_ack, bus.err); end
    checks++; if (bus.p_rdata !== 64'h1234) begin errors++; $display("[TB] FAIL race_rdata got %0h want 1234", bus.p_rdata); end
    bus.p_req = 0;
    tick();
  endtask

  task automatic test_reset_mid_access();
    bus.d_req = 1; bus.d_we = 0; bus.d_addr = 64'h40; bus.m_rdata = 64'h77;
    tick();
    checks++; if (bus.m_valid !== 1'b1 || bus.m_addr !== 64'h40) begin errors++; $display("[TB] FAIL mid_grant got valid %0h addr %0h want 1/40", bus.m_valid, bus.m_addr); end
    tick();
    rst_n = 1'b0;
    #1;
    checks++; if (bus.m_valid !== 1'b0 || bus.m_we !== 1'b0 || bus.m_addr !== 64'h0 || bus.m_wdata !== 64'h0) begin errors++; $display("[TB] FAIL mid_cmd_clear got %0h/%0h/%0h/%0h want 0", bus.m_valid, bus.m_we, bus.m_addr, bus.m_wdata); end
    checks++; if (bus.d_ack !== 1'b0 || bus.p_ack !== 1'b0 || bus.err !== 1'b0 || bus.p_rdata !== 64'h0 || bus.d_rdata !== 64'h0) begin errors++; $display("[TB] FAIL mid_out_clear got ack %0h/%0h err %0h rd %0h/%0h want 0", bus.d_ack, bus.p_ack, bus.err, bus.p_rdata, bus.d_rdata); end
    bus.d_req = 0; bus.p_req = 1; bus.p_we = 1; bus.p_addr = 64'h50; bus.p_wdata = 64'h99;
    tick();
    checks++; if (bus.m_valid !== 1'b0 || bus.d_ack !== 1'b0) begin errors++; $display("[TB] FAIL mid_hold got valid %0h ack %0h want 0/0", bus.m_valid, bus.d_ack); end
    rst_n = 1'b1;
    tick();
    checks++; if (bus.m_valid !== 1'b1 || bus.m_addr !== 64'h50 || bus.m_we !== 1'b1 || bus.m_wdata !== 64'h99) begin errors++; $display("[TB] FAIL mid_regrant got %0h/%0h/%0h/%0h want 1/50/1/99", bus.m_valid, bus.m_addr, bus.m_we, bus.m_wdata); end
    bus.m_done = 1;
    tick();
    bus.m_done = 0;
    checks++; if (bus.p_ack !== 1'b1 || bus.d_ack !== 1'b0) begin errors++; $display("[TB] FAIL mid_ack got p %0h d %0h want 1/0", bus.p_ack, bus.d_ack); end
    bus.p_req = 0;
    tick();
  endtask

  // Safety net so the run can never hang
  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    test_reset();
    test_pipe_load();
    test_debug_write();
    test_starvation();
    test_timeout();
    test_done_at_timeout();
    test_reset_mid_access();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Arbiter and sequencer for the single data memory. It shares the memory between the pipeline MEM stage and a debug/loader port, and runs a valid/done handshake with a memory that may take several cycles. The block sits between the EX/MEM register outputs and the data memory instance. It produces the stall the hazard logic uses to freeze the pipeline while a MEM-stage access is outstanding.

## Interface
Parameters:
- DATA_W, 64, data width
- ADDR_W, 64, address width (ALU result width)
- STARVE_MAX, 4, number of consecutive pipeline grants a waiting debug request tolerates before it is forced through
- TIMEOUT, 16, number of cycles in BUSY without m_done before the access is aborted

Ports:
- clk  in  1  clock; all state changes on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- p_req  in  1  pipeline access request (level), = MemRead_ex_mem | MemWrite_ex_mem
- p_we  in  1  pipeline write enable
- p_addr  in  ADDR_W  pipeline address
- p_wdata  in  DATA_W  pipeline store data
- p_ack  out  1  one-cycle completion pulse for the pipeline
- p_rdata  out  DATA_W  pipeline load data; valid while p_ack is high
- pipe_stall  out  1  freezes PC, IF/ID, ID/EX and EX/MEM
- d_req, d_we, d_addr, d_wdata  in  1/1/ADDR_W/DATA_W  debug request; same semantics as the p_ group
- d_ack  out  1  one-cycle completion pulse for debug
- d_rdata  out  DATA_W  debug load data
- m_valid  out  1  memory command valid
- m_we  out  1  memory write enable
- m_addr  out  ADDR_W  memory address
- m_wdata  out  DATA_W  memory write data
- m_done  in  1  memory completion pulse
- m_rdata  in  DATA_W  memory read data; valid with m_done
- err  out  1  one-cycle pulse when an access is aborted on timeout

## Operation
- FSM states: IDLE, BUSY_P, BUSY_D, RESP.
- Request rules:
  - Requests are level-sensitive. A requester holds req, we, addr and wdata stable until its ack.
- IDLE arbitration:
  - A requester whose ack is high in the current cycle is ignored.
  - Pipeline wins, except when d_req is high and starve_cnt == STARVE_MAX; then debug wins.
  - On a grant, latch the owner's we/addr/wdata into the m_* registers, set m_valid=1, and clear the timeout counter.
- starve_cnt (width clog2(STARVE_MAX+1)):
  - On a pipeline grant while d_req is high: increments, saturating at STARVE_MAX.
  - On a debug grant, or in IDLE with d_req low: clears.
- BUSY_P / BUSY_D:
  - m_* are held constant.
  - When m_done is sampled: capture m_rdata into the owner's rdata register (write accesses capture it too; the value is don't-care), drop m_valid, go to RESP.
  - If the timeout counter reaches TIMEOUT-1 without m_done: drop m_valid, clear the owner's rdata to 0, set err for the RESP cycle, go to RESP.
  - If m_done and timeout occur in the same cycle, m_done wins and err stays 0.
- RESP: the owner's ack is high for exactly one cycle, then the FSM returns to IDLE.
- pipe_stall = p_req & ~p_ack (combinational). The pipeline advances on the p_ack cycle.
- m_done sampled in IDLE or RESP is ignored.
- Debug writes are not coherent with in-flight pipeline loads. Software owns ordering.

## Timing
- Reset values (while rst_n is low, applied immediately):
  - state = IDLE.
  - m_valid, m_we, p_ack, d_ack and err are 0.
  - m_addr, m_wdata, p_rdata, d_rdata, starve_cnt and the timeout counter are 0.
- Reset asserted mid-access:
  - m_valid drops at once and no ack is issued.
  - A request still held after reset is re-arbitrated from IDLE.
- Latency: request sampled at edge k, m_valid high from k+1.
  - m_done in cycle k+1 gives ack in cycle k+2 (minimum 2 cycles).
  - In general, ack comes one cycle after m_done.
- Back-to-back accesses: after ack in cycle n, the next grant is at the end of cycle n+1 (IDLE). Minimum spacing is 3 cycles per access for a 1-cycle memory.
- p_ack and d_ack are never high together. err is high only together with an ack.

## Test plan
- Pipeline load, addr=0x10, memory answers m_done one cycle after m_valid with m_rdata=0xDEAD:
  - m_valid is seen 1 cycle after p_req.
  - p_ack is seen 1 cycle after m_done, with p_rdata=0xDEAD.
  - pipe_stall is high from p_req until the p_ack cycle.
- p_req and d_req rise in the same cycle, with p_req re-asserted after each ack:
  - Pipeline is granted 4 times (STARVE_MAX=4), then debug is granted on the 5th arbitration.
  - starve_cnt returns to 0 after the debug grant.
- Debug write, addr=0x20, wdata=0x55, memory with 3-cycle latency:
  - m_we=1 and m_addr/m_wdata remain stable for all 3 BUSY cycles.
  - d_ack fires once and err=0.
- Memory never asserts m_done:
  - After 16 BUSY cycles, m_valid drops.
  - p_ack and err pulse together with p_rdata=0.
  - The FSM returns to IDLE.
- m_done arrives in the same cycle the timeout expires: ack fires with captured data and err=0.
- rst_n is pulled low in the middle of BUSY_D:
  - All outputs go to 0 immediately.
  - After release, a pending p_req is granted within 1 cycle.
